// File: rtl/branch_predictor_if.sv
// Fetch lookup, resolution update and statistics signals of the branch predictor.
// master = CPU pipeline side, slave = predictor side.
interface branch_predictor_if #(
  parameter int unsigned WORD_SIZE = 16
);
  logic [WORD_SIZE-1:0] fetch_pc;
  logic                 pred_taken;
  logic [WORD_SIZE-1:0] pred_target;
  logic                 upd_valid;
  logic [WORD_SIZE-1:0] upd_pc;
  logic                 upd_taken;
  logic [WORD_SIZE-1:0] upd_target;
  logic                 upd_pred_taken;
  logic [WORD_SIZE-1:0] upd_pred_target;
  logic                 mispredict;
  logic [WORD_SIZE-1:0] correct_pc;
  logic [WORD_SIZE-1:0] num_branch;
  logic [WORD_SIZE-1:0] num_branch_miss;

  modport master (
    output fetch_pc, upd_valid, upd_pc, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target,
    input  pred_taken, pred_target, mispredict, correct_pc,
           num_branch, num_branch_miss
  );

  modport slave (
    input  fetch_pc, upd_valid, upd_pc, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target,
    output pred_taken, pred_target, mispredict, correct_pc,
           num_branch, num_branch_miss
  );
endinterface

// File: rtl/branch_predictor.sv
// Branch predictor: direct-mapped BTB plus saturating-counter table, mode selected
// by parameter (none / always-untaken / always-taken / bimodal / gshare).
module branch_predictor #(
  parameter int unsigned WORD_SIZE    = 16,
  parameter int unsigned MODE         = 3,
  parameter int unsigned INDEX_BITS   = 8,
  parameter int unsigned COUNTER_BITS = 2,
  parameter int unsigned HIST_BITS    = 8
) (
  input logic               clk,
  input logic               reset_n,
  branch_predictor_if.slave bp
);
  localparam int unsigned NUM_ENTRIES = 1 << INDEX_BITS;
  localparam int unsigned TAG_BITS    = WORD_SIZE - INDEX_BITS;
  localparam bit          USE_BTB     = (MODE >= 2);
  localparam bit          USE_CNT     = (MODE == 3) || (MODE == 4);
  localparam bit          USE_GHR     = (MODE == 4);
  localparam logic [COUNTER_BITS-1:0] CNT_MAX  = {COUNTER_BITS{1'b1}};
  localparam logic [COUNTER_BITS-1:0] CNT_WEAK = COUNTER_BITS'(1 << (COUNTER_BITS - 1));

  logic                    btb_valid_q [NUM_ENTRIES];
  logic [TAG_BITS-1:0]     btb_tag_q   [NUM_ENTRIES];
  logic [WORD_SIZE-1:0]    btb_tgt_q   [NUM_ENTRIES];
  logic [COUNTER_BITS-1:0] cnt_q       [NUM_ENTRIES];

  logic [HIST_BITS-1:0]    ghr_q, ghr_d;
  logic [WORD_SIZE-1:0]    num_branch_q, num_branch_d;
  logic [WORD_SIZE-1:0]    num_miss_q, num_miss_d;

  logic [INDEX_BITS-1:0]   f_idx, f_cidx, u_idx, u_cidx;
  logic [TAG_BITS-1:0]     f_tag, u_tag;
  logic                    f_hit, pred_taken_c, mispredict_c;
  logic [COUNTER_BITS-1:0] cnt_cur, cnt_d;

  // Fetch-side lookup; reads only registered state, so no same-cycle bypass.
  always_comb begin
    f_idx        = bp.fetch_pc[INDEX_BITS-1:0];
    f_tag        = bp.fetch_pc[WORD_SIZE-1:INDEX_BITS];
    f_cidx       = USE_GHR ? (f_idx ^ INDEX_BITS'(ghr_q)) : f_idx;
    f_hit        = btb_valid_q[f_idx] && (btb_tag_q[f_idx] == f_tag);
    pred_taken_c = 1'b0;
    if (MODE == 2) begin
      pred_taken_c = f_hit;
    end else if (USE_CNT) begin
      pred_taken_c = f_hit && cnt_q[f_cidx][COUNTER_BITS-1];
    end
    pred_taken_c    = pred_taken_c && reset_n;
    bp.pred_taken   = pred_taken_c;
    bp.pred_target  = pred_taken_c ? btb_tgt_q[f_idx] : bp.fetch_pc + WORD_SIZE'(1);
  end

  // Resolution side: misprediction flag, redirect PC and next-state values.
  always_comb begin
    u_idx   = bp.upd_pc[INDEX_BITS-1:0];
    u_tag   = bp.upd_pc[WORD_SIZE-1:INDEX_BITS];
    u_cidx  = USE_GHR ? (u_idx ^ INDEX_BITS'(ghr_q)) : u_idx;
    cnt_cur = cnt_q[u_cidx];

    mispredict_c = (MODE != 0) && bp.upd_valid &&
                   ((bp.upd_pred_taken != bp.upd_taken) ||
                    (bp.upd_taken && (bp.upd_pred_target != bp.upd_target)));
    bp.mispredict = mispredict_c;
    bp.correct_pc = bp.upd_taken ? bp.upd_target : bp.upd_pc + WORD_SIZE'(1);

    cnt_d = cnt_cur;
    if (bp.upd_taken) begin
      if (cnt_cur != CNT_MAX) cnt_d = cnt_cur + COUNTER_BITS'(1);
    end else begin
      if (cnt_cur != '0) cnt_d = cnt_cur - COUNTER_BITS'(1);
    end

    ghr_d        = ghr_q;
    num_branch_d = num_branch_q;
    num_miss_d   = num_miss_q;
    if (bp.upd_valid) begin
      // Dropping the top bit of the concatenation shifts the outcome in.
      ghr_d        = HIST_BITS'({ghr_q, bp.upd_taken});
      num_branch_d = num_branch_q + WORD_SIZE'(1);
      if (mispredict_c) num_miss_d = num_miss_q + WORD_SIZE'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
        btb_valid_q[i] <= 1'b0;
        cnt_q[i]       <= CNT_WEAK;
      end
      ghr_q        <= '0;
      num_branch_q <= '0;
      num_miss_q   <= '0;
    end else begin
      if (USE_BTB && bp.upd_valid && bp.upd_taken) btb_valid_q[u_idx] <= 1'b1;
      if (USE_CNT && bp.upd_valid) cnt_q[u_cidx] <= cnt_d;
      if (USE_GHR) ghr_q <= ghr_d;
      num_branch_q <= num_branch_d;
      num_miss_q   <= num_miss_d;
    end
  end

  // Tag and target payload need no reset: qualified by the valid bit.
  always_ff @(posedge clk) begin
    if (USE_BTB && reset_n && bp.upd_valid && bp.upd_taken) begin
      btb_tag_q[u_idx] <= u_tag;
      btb_tgt_q[u_idx] <= bp.upd_target;
    end
  end

  assign bp.num_branch      = num_branch_q;
  assign bp.num_branch_miss = num_miss_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench: three predictor configurations (bimodal, gshare, mode 0 with
// 8-bit words) driven in lockstep and compared against an arithmetic reference model.
module tb_branch_predictor;
  localparam int NI = 3;
  localparam int CFG_MODE [NI] = '{3, 4, 0};
  localparam int CFG_WS   [NI] = '{16, 16, 8};
  localparam int CFG_IB   [NI] = '{8, 8, 4};
  localparam int CFG_HB   [NI] = '{8, 2, 4};
  localparam int CFG_CB   [NI] = '{2, 2, 2};

  typedef struct {
    int k;
    int pt;
    int ptgt;
    int mis;
    int cpc;
    int nb;
    int nm;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  branch_predictor_if #(.WORD_SIZE(16)) b3 ();
  branch_predictor_if #(.WORD_SIZE(16)) b4 ();
  branch_predictor_if #(.WORD_SIZE(8))  b0 ();

  branch_predictor #(.WORD_SIZE(16), .MODE(3), .INDEX_BITS(8), .COUNTER_BITS(2), .HIST_BITS(8))
    u_bimodal (.clk(clk), .reset_n(reset_n), .bp(b3));
  branch_predictor #(.WORD_SIZE(16), .MODE(4), .INDEX_BITS(8), .COUNTER_BITS(2), .HIST_BITS(2))
    u_gshare (.clk(clk), .reset_n(reset_n), .bp(b4));
  branch_predictor #(.WORD_SIZE(8), .MODE(0), .INDEX_BITS(4), .COUNTER_BITS(2), .HIST_BITS(4))
    u_none (.clk(clk), .reset_n(reset_n), .bp(b0));

  // Reference model state
  bit m_valid [NI][256];
  int m_tag   [NI][256];
  int m_tgt   [NI][256];
  int m_cnt   [NI][256];
  int m_ghr   [NI];
  int m_nb    [NI];
  int m_nm    [NI];

  exp_t sbq[$];
  exp_t mon_e, mon_a;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   rst_level = 1'b0;

  function automatic void chk(input string nm, input int k, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s inst%0d: actual 0x%0h required 0x%0h (t=%0t)", nm, k, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 256; i++) begin
        m_valid[k][i] = 1'b0;
        m_tag[k][i]   = 0;
        m_tgt[k][i]   = 0;
        m_cnt[k][i]   = 1 << (CFG_CB[k] - 1);
      end
      m_ghr[k] = 0;
      m_nb[k]  = 0;
      m_nm[k]  = 0;
    end
  endfunction

  function automatic void model_lookup(input int k, input int pc, output int pt, output int tgt);
    int mask, n, idx, tag, cidx;
    bit hit;
    mask = (1 << CFG_WS[k]) - 1;
    n    = 1 << CFG_IB[k];
    idx  = pc % n;
    tag  = pc / n;
    cidx = (CFG_MODE[k] == 4) ? (idx ^ m_ghr[k]) : idx;
    hit  = m_valid[k][idx] && (m_tag[k][idx] == tag);
    case (CFG_MODE[k])
      2:       pt = hit ? 1 : 0;
      3, 4:    pt = (hit && (m_cnt[k][cidx] >= (1 << (CFG_CB[k] - 1)))) ? 1 : 0;
      default: pt = 0;
    endcase
    tgt = (pt != 0) ? m_tgt[k][idx] : ((pc + 1) & mask);
  endfunction

  function automatic void model_update(input int k, input int u, input bit t, input int ut,
                                       input int mis);
    int mask, n, idx, cidx, cmax;
    mask = (1 << CFG_WS[k]) - 1;
    n    = 1 << CFG_IB[k];
    idx  = u % n;
    cidx = (CFG_MODE[k] == 4) ? (idx ^ m_ghr[k]) : idx;
    cmax = (1 << CFG_CB[k]) - 1;
    if (CFG_MODE[k] >= 2 && t) begin
      m_valid[k][idx] = 1'b1;
      m_tag[k][idx]   = u / n;
      m_tgt[k][idx]   = ut;
    end
    if (CFG_MODE[k] == 3 || CFG_MODE[k] == 4) begin
      if (t) m_cnt[k][cidx] = (m_cnt[k][cidx] < cmax) ? m_cnt[k][cidx] + 1 : cmax;
      else   m_cnt[k][cidx] = (m_cnt[k][cidx] > 0) ? m_cnt[k][cidx] - 1 : 0;
    end
    if (CFG_MODE[k] == 4) m_ghr[k] = ((m_ghr[k] << 1) | int'(t)) % (1 << CFG_HB[k]);
    m_nb[k] = (m_nb[k] + 1) & mask;
    if (mis != 0) m_nm[k] = (m_nm[k] + 1) & mask;
  endfunction

  task automatic drive(input int k, input int f, input bit v, input int u, input bit t,
                       input int ut, input int upt, input int uptg);
    case (k)
      0: begin
        b3.fetch_pc = 16'(f); b3.upd_valid = v; b3.upd_pc = 16'(u); b3.upd_taken = t;
        b3.upd_target = 16'(ut); b3.upd_pred_taken = (upt != 0); b3.upd_pred_target = 16'(uptg);
      end
      1: begin
        b4.fetch_pc = 16'(f); b4.upd_valid = v; b4.upd_pc = 16'(u); b4.upd_taken = t;
        b4.upd_target = 16'(ut); b4.upd_pred_taken = (upt != 0); b4.upd_pred_target = 16'(uptg);
      end
      default: begin
        b0.fetch_pc = 8'(f); b0.upd_valid = v; b0.upd_pc = 8'(u); b0.upd_taken = t;
        b0.upd_target = 8'(ut); b0.upd_pred_taken = (upt != 0); b0.upd_pred_target = 8'(uptg);
      end
    endcase
  endtask

  function automatic exp_t sample(input int k);
    exp_t a;
    a.k = k;
    case (k)
      0: begin
        a.pt = int'(b3.pred_taken); a.ptgt = int'(b3.pred_target); a.mis = int'(b3.mispredict);
        a.cpc = int'(b3.correct_pc); a.nb = int'(b3.num_branch); a.nm = int'(b3.num_branch_miss);
      end
      1: begin
        a.pt = int'(b4.pred_taken); a.ptgt = int'(b4.pred_target); a.mis = int'(b4.mispredict);
        a.cpc = int'(b4.correct_pc); a.nb = int'(b4.num_branch); a.nm = int'(b4.num_branch_miss);
      end
      default: begin
        a.pt = int'(b0.pred_taken); a.ptgt = int'(b0.pred_target); a.mis = int'(b0.mispredict);
        a.cpc = int'(b0.correct_pc); a.nb = int'(b0.num_branch); a.nm = int'(b0.num_branch_miss);
      end
    endcase
    return a;
  endfunction

  // Apply one cycle of stimulus to every instance and queue the expected response.
  task automatic cycle(input int fpc, input bit v, input int upc, input bit t, input int utgt,
                       input bit honest, input bit upt_r, input int uptg_r);
    reset_n = rst_level;
    if (!rst_level) model_reset();
    for (int k = 0; k < NI; k++) begin
      int   mask, f, u, ut, pt, ptg, upt, uptg, mis, cpc;
      exp_t e;
      mask = (1 << CFG_WS[k]) - 1;
      f    = fpc & mask;
      u    = upc & mask;
      ut   = utgt & mask;
      if (honest) model_lookup(k, u, upt, uptg);
      else begin
        upt  = int'(upt_r);
        uptg = uptg_r & mask;
      end
      drive(k, f, v, u, t, ut, upt, uptg);
      model_lookup(k, f, pt, ptg);
      mis = (CFG_MODE[k] != 0 && v && ((upt != int'(t)) || (t && uptg != ut))) ? 1 : 0;
      cpc = t ? ut : ((u + 1) & mask);
      e.k = k; e.pt = pt; e.ptgt = ptg; e.mis = mis; e.cpc = cpc; e.nb = m_nb[k]; e.nm = m_nm[k];
      sbq.push_back(e);
      if (rst_level && v) model_update(k, u, t, ut, mis);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int fpc);
    cycle(fpc, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0);
  endtask

  task automatic do_reset();
    rst_level = 1'b0;
    // An update presented while reset is held must be discarded.
    cycle(16'h0010, 1'b1, 16'h0010, 1'b1, 16'h0040, 1'b0, 1'b0, 0);
    step();
    cycle(16'h0010, 1'b1, 16'h0010, 1'b1, 16'h0040, 1'b0, 1'b0, 0);
    step();
    rst_level = 1'b1;
  endtask

  function automatic int pick_pc();
    case ($urandom_range(0, 7))
      0: return 16'h0010;
      1: return 16'h0110;
      2: return 16'h0020;
      3: return 16'h00FF;
      4: return 16'hFFFF;
      5: return 16'h1210;
      6: return 16'h0023;
      default: return int'($urandom_range(0, 16'hFFFF));
    endcase
  endfunction

  // Monitor: the predictor presents a response every cycle; compare against queue.
  always @(negedge clk) begin
    while (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      mon_a = sample(mon_e.k);
      chk("sb pred_taken",      mon_e.k, mon_a.pt,   mon_e.pt);
      chk("sb pred_target",     mon_e.k, mon_a.ptgt, mon_e.ptgt);
      chk("sb mispredict",      mon_e.k, mon_a.mis,  mon_e.mis);
      chk("sb correct_pc",      mon_e.k, mon_a.cpc,  mon_e.cpc);
      chk("sb num_branch",      mon_e.k, mon_a.nb,   mon_e.nb);
      chk("sb num_branch_miss", mon_e.k, mon_a.nm,   mon_e.nm);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t s;
    reset_n = 1'b0;
    model_reset();
    for (int k = 0; k < NI; k++) drive(k, 0, 1'b0, 0, 1'b0, 0, 0, 0);
    step();

    // Bimodal: reset state, training, alias, saturation
    do_reset();
    idle(16'h0010); #2;
    s = sample(0);
    chk("reset pred_taken", 0, s.pt, 0);
    chk("reset pred_target", 0, s.ptgt, 16'h0011);
    chk("reset num_branch", 0, s.nb, 0);
    chk("reset num_branch_miss", 0, s.nm, 0);
    step();

    cycle(16'h0010, 1'b1, 16'h0010, 1'b1, 16'h0040, 1'b0, 1'b0, 16'h0011); #2;
    s = sample(0);
    chk("train mispredict", 0, s.mis, 1);
    chk("train correct_pc", 0, s.cpc, 16'h0040);
    chk("train no bypass pred_taken", 0, s.pt, 0);
    step();

    idle(16'h0010); #2;
    s = sample(0);
    chk("trained pred_taken", 0, s.pt, 1);
    chk("trained pred_target", 0, s.ptgt, 16'h0040);
    chk("trained num_branch", 0, s.nb, 1);
    chk("trained num_branch_miss", 0, s.nm, 1);
    step();

    idle(16'h0110); #2;
    s = sample(0);
    chk("alias pred_taken", 0, s.pt, 0);
    chk("alias pred_target", 0, s.ptgt, 16'h0111);
    step();

    for (int i = 0; i < 4; i++) begin
      cycle(16'h0010, 1'b1, 16'h0010, 1'b0, 0, 1'b1, 1'b0, 0);
      step();
      idle(16'h0010); #2;
      s = sample(0);
      chk("saturate pred_taken", 0, s.pt, (i == 0) ? 1 : 0);
      step();
    end
    cycle(16'h0010, 1'b1, 16'h0010, 1'b1, 16'h0040, 1'b1, 1'b0, 0);
    step();
    idle(16'h0010); #2;
    s = sample(0);
    chk("after floor taken pred_taken", 0, s.pt, 0);
    chk("after floor pred_target", 0, s.ptgt, 16'h0011);
    step();

    // Gshare: T,T -> ghr 11; then N,T,T leaves counter 0x23 below threshold
    do_reset();
    for (int i = 0; i < 2; i++) begin
      cycle(16'h0020, 1'b1, 16'h0020, 1'b1, 16'h0050, 1'b1, 1'b0, 0);
      step();
    end
    idle(16'h0020); #2;
    s = sample(1);
    chk("gshare TT pred_taken", 1, s.pt, 1);
    chk("gshare TT pred_target", 1, s.ptgt, 16'h0050);
    step();
    cycle(16'h0020, 1'b1, 16'h0020, 1'b0, 0, 1'b1, 1'b0, 0);
    step();
    for (int i = 0; i < 2; i++) begin
      cycle(16'h0020, 1'b1, 16'h0020, 1'b1, 16'h0050, 1'b1, 1'b0, 0);
      step();
    end
    idle(16'h0020); #2;
    s = sample(1);
    chk("gshare hist pred_taken", 1, s.pt, 0);
    chk("gshare hist pred_target", 1, s.ptgt, 16'h0021);
    s = sample(0);
    chk("bimodal same seq pred_taken", 0, s.pt, 1);
    step();

    // Mode 0 with 8-bit words: no mispredicts, counter wraps at 256
    do_reset();
    cycle(16'h0010, 1'b1, 16'h0010, 1'b1, 16'h0040, 1'b0, 1'b0, 0); #2;
    s = sample(2);
    chk("mode0 mispredict", 2, s.mis, 0);
    chk("mode0 correct_pc", 2, s.cpc, 8'h40);
    step();
    for (int i = 1; i < 255; i++) begin
      cycle(pick_pc(), 1'b1, pick_pc(), 1'($urandom_range(0, 1)), pick_pc(), 1'b0,
            1'($urandom_range(0, 1)), pick_pc());
      step();
    end
    idle(16'h0000); #2;
    s = sample(2);
    chk("mode0 num_branch 255", 2, s.nb, 8'hFF);
    step();
    cycle(16'h0000, 1'b1, 16'h0030, 1'b1, 16'h0099, 1'b0, 1'b0, 0);
    step();
    idle(16'h0000); #2;
    s = sample(2);
    chk("mode0 num_branch wrap", 2, s.nb, 0);
    chk("mode0 num_branch_miss", 2, s.nm, 0);
    s = sample(0);
    chk("bimodal num_branch 256", 0, s.nb, 16'h0100);
    step();

    // Randomised traffic with occasional resets
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      if ($urandom_range(0, 3) == 0) idle(pick_pc());
      else cycle(pick_pc(), 1'b1, pick_pc(), 1'($urandom_range(0, 1)), pick_pc(),
                 ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), pick_pc());
      step();
    end
    idle(16'h0000);
    step();

    for (int i = 0; i < 5 && sbq.size() > 0; i++) @(negedge clk);
    #1;
    chk("scoreboard drained", 0, sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
